// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for Montgomery modular exponentiation.
// Drives an external Montgomery multiplier and reduction unit through request/response pulses.
module mont_exp_ctrl #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned EXP_WIDTH = 512
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     base_mont,
    input  logic [WIDTH-1:0]     one_mont,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic                 valid_in,
    output logic [WIDTH-1:0]     mul_a_out,
    output logic [WIDTH-1:0]     mul_b_out,
    output logic                 mul_valid_out,
    input  logic [WIDTH-1:0]     mul_result_in,
    input  logic                 mul_valid_in,
    output logic [WIDTH-1:0]     red_x_out,
    output logic                 red_valid_out,
    input  logic [WIDTH-1:0]     red_result_in,
    input  logic                 red_valid_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 valid_out,
    output logic                 busy_out
);

    localparam int unsigned IdxW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSqReq,
        StSqWait,
        StMulReq,
        StMulWait,
        StRedReq,
        StRedWait
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 valid_q, valid_d;

    logic [IdxW-1:0]      msb_idx;
    logic                 exp_zero;
    logic                 accept;

    // Priority encoder: highest set bit of the incoming exponent wins.
    always_comb begin
        msb_idx = '0;
        for (int unsigned i = 0; i < EXP_WIDTH; i++) begin
            if (exponent[i]) begin
                msb_idx = IdxW'(i);
            end
        end
    end

    assign exp_zero = (exponent == '0);
    // The valid_out cycle still counts as busy, so accepts wait one more cycle.
    assign accept   = valid_in && (state_q == StIdle) && !valid_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        result_d = result_q;
        valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    base_d = base_mont;
                    exp_d  = exponent;
                    if (exp_zero) begin
                        acc_d   = one_mont;
                        idx_d   = '0;
                        state_d = StRedReq;
                    end else if (msb_idx == '0) begin
                        acc_d   = base_mont;
                        idx_d   = '0;
                        state_d = StRedReq;
                    end else begin
                        // Leading square of one is skipped by starting from the base.
                        acc_d   = base_mont;
                        idx_d   = msb_idx - 1'b1;
                        state_d = StSqReq;
                    end
                end
            end
            StSqReq: begin
                state_d = StSqWait;
            end
            StSqWait: begin
                if (mul_valid_in) begin
                    acc_d = mul_result_in;
                    if (exp_q[idx_q]) begin
                        state_d = StMulReq;
                    end else if (idx_q == '0) begin
                        state_d = StRedReq;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StSqReq;
                    end
                end
            end
            StMulReq: begin
                state_d = StMulWait;
            end
            StMulWait: begin
                if (mul_valid_in) begin
                    acc_d = mul_result_in;
                    if (idx_q == '0) begin
                        state_d = StRedReq;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StSqReq;
                    end
                end
            end
            StRedReq: begin
                state_d = StRedWait;
            end
            StRedWait: begin
                if (red_valid_in) begin
                    result_d = red_result_in;
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // Operands stay on the bus through the whole wait so the datapaths need no input latch.
    always_comb begin
        mul_a_out     = '0;
        mul_b_out     = '0;
        mul_valid_out = 1'b0;
        red_x_out     = '0;
        red_valid_out = 1'b0;

        unique case (state_q)
            StSqReq, StSqWait: begin
                mul_a_out     = acc_q;
                mul_b_out     = acc_q;
                mul_valid_out = (state_q == StSqReq);
            end
            StMulReq, StMulWait: begin
                mul_a_out     = acc_q;
                mul_b_out     = base_q;
                mul_valid_out = (state_q == StMulReq);
            end
            StRedReq, StRedWait: begin
                red_x_out     = acc_q;
                red_valid_out = (state_q == StRedReq);
            end
            default: begin
            end
        endcase
    end

    assign result_out = result_q;
    assign valid_out  = valid_q;
    assign busy_out   = (state_q != StIdle) || valid_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier/reduction models and a result
// scoreboard, WIDTH = EXP_WIDTH = 16, N = 33227.
module tb_mont_exp_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned EW = 16;
    localparam logic [63:0] ModN = 64'd33227;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [W-1:0]  base_mont = '0;
    logic [W-1:0]  one_mont = '0;
    logic [EW-1:0] exponent = '0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  mul_a_out, mul_b_out;
    logic          mul_valid_out;
    logic [W-1:0]  mul_result_in = '0;
    logic          mul_valid_in = 1'b0;
    logic [W-1:0]  red_x_out;
    logic          red_valid_out;
    logic [W-1:0]  red_result_in = '0;
    logic          red_valid_in = 1'b0;
    logic [W-1:0]  result_out;
    logic          valid_out;
    logic          busy_out;

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .base_mont     (base_mont),
        .one_mont      (one_mont),
        .exponent      (exponent),
        .valid_in      (valid_in),
        .mul_a_out     (mul_a_out),
        .mul_b_out     (mul_b_out),
        .mul_valid_out (mul_valid_out),
        .mul_result_in (mul_result_in),
        .mul_valid_in  (mul_valid_in),
        .red_x_out     (red_x_out),
        .red_valid_out (red_valid_out),
        .red_result_in (red_result_in),
        .red_valid_in  (red_valid_in),
        .result_out    (result_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Bit-serial REDC: a*b*2^-16 mod N.
    function automatic logic [15:0] mont_mul(input logic [15:0] a, input logic [15:0] b);
        logic [63:0] t;
        t = 64'(a) * 64'(b);
        for (int i = 0; i < 16; i++) begin
            if (t[0]) t = t + ModN;
            t = t >> 1;
        end
        if (t >= ModN) t = t - ModN;
        return t[15:0];
    endfunction

    function automatic logic [15:0] to_mont(input logic [15:0] x);
        logic [63:0] t;
        t = (64'(x) << 16) % ModN;
        return t[15:0];
    endfunction

    function automatic logic [15:0] modpow(input logic [15:0] b, input logic [15:0] e);
        logic [63:0] r;
        logic [63:0] bb;
        r  = 64'd1;
        bb = 64'(b) % ModN;
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % ModN;
            if (e[i]) r = (r * bb) % ModN;
        end
        return r[15:0];
    endfunction

    // Datapath models and output monitor, all on the falling edge.
    int            mul_cnt = 0;
    int            red_cnt = 0;
    int            mul_lat_min = 5;
    int            mul_lat_max = 5;
    logic [15:0]   ma, mb, rx;
    int            mul_pulses = 0;
    int            red_pulses = 0;
    int            done_cnt = 0;
    logic [15:0]   sb_q[$];
    logic [15:0]   want_r;

    always @(negedge clk_in) begin
        mul_valid_in = 1'b0;
        red_valid_in = 1'b0;
        if (mul_cnt != 0) begin
            mul_cnt--;
            if (mul_cnt == 0) begin
                mul_result_in = mont_mul(ma, mb);
                mul_valid_in  = 1'b1;
            end
        end else if (mul_valid_out) begin
            ma      = mul_a_out;
            mb      = mul_b_out;
            mul_cnt = int'($urandom_range(mul_lat_max, mul_lat_min));
        end
        if (red_cnt != 0) begin
            red_cnt--;
            if (red_cnt == 0) begin
                red_result_in = mont_mul(rx, 16'd1);
                red_valid_in  = 1'b1;
            end
        end else if (red_valid_out) begin
            rx      = red_x_out;
            red_cnt = 7;
        end
        if (mul_valid_out) mul_pulses++;
        if (red_valid_out) red_pulses++;
        if (valid_out) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("spurious_valid_out", 64'(valid_out), 64'd0);
            end else begin
                want_r = sb_q.pop_front();
                check_val("result", 64'(result_out), 64'(want_r));
            end
        end
    end

    task automatic run(input logic [15:0] b, input logic [15:0] e, input logic [15:0] want,
                       input int want_mul, input bit poke);
        int start_done;
        @(negedge clk_in);
        mul_pulses = 0;
        red_pulses = 0;
        start_done = done_cnt;
        base_mont  = b;
        one_mont   = to_mont(16'd1);
        exponent   = e;
        valid_in   = 1'b1;
        sb_q.push_back(want);
        @(negedge clk_in);
        valid_in  = 1'b0;
        base_mont = '0;
        exponent  = '0;
        check_val("busy_after_accept", 64'(busy_out), 64'd1);
        if (poke) begin
            repeat (12) @(negedge clk_in);
            base_mont = to_mont(16'd7);
            exponent  = 16'h0003;
            valid_in  = 1'b1;
            @(negedge clk_in);
            valid_in  = 1'b0;
        end
        for (int i = 0; i < 5000 && done_cnt == start_done; i++) @(negedge clk_in);
        check_val("done_count", 64'(done_cnt - start_done), 64'd1);
        check_val("mul_pulses", 64'(mul_pulses), 64'(want_mul));
        check_val("red_pulses", 64'(red_pulses), 64'd1);
        @(negedge clk_in);
        check_val("busy_after_done", 64'(busy_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int snap;
        repeat (2) @(negedge clk_in);
        check_val("rst_busy", 64'(busy_out), 64'd0);
        check_val("rst_valid", 64'(valid_out), 64'd0);
        check_val("rst_result", 64'(result_out), 64'd0);
        check_val("rst_mul_valid", 64'(mul_valid_out), 64'd0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        run(to_mont(16'd46), 16'd5, 16'd22030, 3, 1'b0);
        run(to_mont(16'd1234), 16'd0, 16'd1, 0, 1'b0);
        run(to_mont(16'd46), 16'd1, 16'd46, 0, 1'b0);
        mul_lat_min = 1;
        mul_lat_max = 20;
        run(to_mont(16'd3), 16'hFFFF, modpow(16'd3, 16'hFFFF), 30, 1'b0);
        mul_lat_min = 5;
        mul_lat_max = 5;

        // Second request mid-run must be dropped, not queued.
        run(to_mont(16'd46), 16'd5, 16'd22030, 3, 1'b1);
        snap = done_cnt;
        repeat (60) @(negedge clk_in);
        check_val("no_queued_run", 64'(done_cnt - snap), 64'd0);

        // Reset while waiting on a square; the late product must be ignored.
        base_mont = to_mont(16'd46);
        one_mont  = to_mont(16'd1);
        exponent  = 16'd5;
        valid_in  = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        for (int i = 0; i < 50 && !mul_valid_out; i++) @(negedge clk_in);
        check_val("sq_req_seen", 64'(mul_valid_out), 64'd1);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check_val("mid_rst_busy", 64'(busy_out), 64'd0);
        check_val("mid_rst_mul_valid", 64'(mul_valid_out), 64'd0);
        check_val("mid_rst_mul_a", 64'(mul_a_out), 64'd0);
        check_val("mid_rst_mul_b", 64'(mul_b_out), 64'd0);
        check_val("mid_rst_red_valid", 64'(red_valid_out), 64'd0);
        check_val("mid_rst_red_x", 64'(red_x_out), 64'd0);
        check_val("mid_rst_result", 64'(result_out), 64'd0);
        check_val("mid_rst_valid", 64'(valid_out), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        snap = done_cnt;
        repeat (40) @(negedge clk_in);
        check_val("post_rst_idle_busy", 64'(busy_out), 64'd0);
        check_val("post_rst_no_result", 64'(done_cnt - snap), 64'd0);
        check_val("post_rst_mul_valid", 64'(mul_valid_out), 64'd0);

        run(to_mont(16'd46), 16'd5, 16'd22030, 3, 1'b0);

        check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
